butterfly_ctrl: RTL
===================

Name: butterfly_ctrl

Overview:
- Control sequencer that drives the control inputs of the butterfly datapath for one radix-2 butterfly: X = a + w·b, Y = a − w·b.
- On a start request it captures the operands, then runs the real-part and imag-part accumulate sequences through the shared multiplier and the two accumulators.
- It writes both result words to the output register and returns a done pulse.
- It sits between the FFT stage scheduler (start/hold/done) and one butterfly instance.

Parameters:
- NO_COMP_WORD, 2, width of data_in_addr. Only values 0 and 1 are issued; the upper bits are always 0.
- CNT_WIDTH, 8, width of the completed-butterfly counter.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  request one butterfly. Sampled only in IDLE or DONE.
- hold  input  1  stall. Freezes the FSM and gates all enables low.
- data_in_en  output  1  operand register capture enable.
- data_in_addr  output  NO_COMP_WORD  operand select. 0 = {a_r, b_r}; 1 = {a_i, b_i}.
- w_addr  output  1  twiddle select. 0 = w_r; 1 = w_i.
- acu_enable  output  1  accumulator update enable (both accumulators).
- acu_load1, acu_load2  output  1 each  load accumulator with a (sign-extended) instead of accumulating.
- acu_cin1, acu_cin2  output  1 each  1 = subtract the product; 0 = add it.
- data_out_en  output  1  result register write enable.
- data_out_addr  output  1  result word select. 0 = real; 1 = imag.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when both result words are written.
- bf_count  output  CNT_WIDTH  completed butterflies since reset. Wraps modulo 2^CNT_WIDTH.

Behaviour:
- States, with the outputs driven in each (anything not listed is 0):
  - IDLE: all outputs 0.
  - CAP: data_in_en = 1.
  - RL: addr = 0, w = 0, acu_enable = 1, load1 = load2 = 1. Both accumulators take a_r.
  - R1: addr = 0, w = 0, acu_enable = 1, cin1 = 0, cin2 = 1. X += b_r·w_r; Y −= b_r·w_r.
  - R2: addr = 1, w = 1, acu_enable = 1, cin1 = 1, cin2 = 0. X −= b_i·w_i; Y += b_i·w_i.
  - RW: data_out_en = 1, data_out_addr = 0.
  - IL: addr = 1, acu_enable = 1, load1 = load2 = 1. Both accumulators take a_i.
  - I1: addr = 0, w = 1, acu_enable = 1, cin1 = 0, cin2 = 1. Product b_r·w_i.
  - I2: addr = 1, w = 0, acu_enable = 1, cin1 = 0, cin2 = 1. Product b_i·w_r.
  - IW: data_out_en = 1, data_out_addr = 1.
  - DONE: done = 1.
- Transitions:
  - IDLE goes to CAP on start = 1; otherwise it stays in IDLE.
  - CAP, RL, R1, R2, RW, IL, I1, I2 and IW each advance to the next state unconditionally, one state per cycle.
  - DONE goes to CAP if start = 1 (back-to-back butterfly, no idle cycle); otherwise it goes to IDLE.
- Output timing:
  - State and all select/load/cin outputs are registered. The register holds the table value of the current state; there is no combinational input-to-output path except hold gating.
  - data_in_en, acu_enable, data_out_en and done are the registered value AND NOT hold.
- Latency: start sampled high in IDLE at edge 0 gives CAP in cycle 1 and done high in cycle 10. Back-to-back operation delivers one butterfly per 10 cycles.
- hold:
  - While hold = 1, the state register, select outputs, load/cin outputs and bf_count do not change, and start is ignored.
  - Gated enables are 0 while hold = 1. Operation resumes in the same state when hold drops.
  - hold during DONE delays the done pulse to the first cycle with hold = 0.
- start while busy (CAP..IW) is ignored and not queued.
- bf_count increments by 1 in each cycle where done = 1. It wraps from 2^CNT_WIDTH − 1 to 0.
- Reset (asynchronous, any state, including mid-sequence): state = IDLE, every output 0, bf_count = 0. Partial results in the datapath are abandoned. The first start after rst falls begins a fresh sequence.
- The data_in_addr upper bits (NO_COMP_WORD − 1 : 1) are tied to 0.

Test Plan:
- Reset and idle: assert rst mid-R2 → all outputs 0 asynchronously, busy = 0, bf_count = 0. After release, with start held low for 20 cycles, state stays IDLE and all outputs stay 0.
- Single butterfly: one-cycle start pulse → exact per-state table over cycles 1–9, done = 1 in cycle 10 only, busy high in cycles 1–10, bf_count = 1.
- Integrated with the butterfly datapath (Q4.5 format, real_w = 16, imag_w = −16):
  - Stimulus: a = (32, 16), b = (16, 8).
  - Required: out1 = (44, 12), out2 = (20, 20).
- Back-to-back: start held high for 35 cycles → done pulses in cycles 10, 20 and 30, CAP follows DONE with no IDLE gap, bf_count = 3.
- Hold: hold = 1 for 3 cycles while in R1 → state frozen, acu_enable = 0 for those 3 cycles, done delayed by 3 cycles, results unchanged. hold during DONE → done appears on the first cycle with hold = 0.
- Wrap and ignored start: CNT_WIDTH = 2 with 5 butterflies → bf_count sequence 1, 2, 3, 0, 1. A start pulse during I1 does not add an extra butterfly.

Source files
------------

// File: rtl/butterfly_ctrl.sv
// Control sequencer for one radix-2 butterfly (X = a + w*b, Y = a - w*b):
// it steps the shared multiplier/accumulator datapath through the real and imag passes.
module butterfly_ctrl #(
    parameter int NO_COMP_WORD = 2,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    hold,
    output logic                    data_in_en,
    output logic [NO_COMP_WORD-1:0] data_in_addr,
    output logic                    w_addr,
    output logic                    acu_enable,
    output logic                    acu_load1,
    output logic                    acu_load2,
    output logic                    acu_cin1,
    output logic                    acu_cin2,
    output logic                    data_out_en,
    output logic                    data_out_addr,
    output logic                    busy,
    output logic                    done,
    output logic [CNT_WIDTH-1:0]    bf_count
);

    typedef enum logic [3:0] {
        S_IDLE, S_CAP,
        S_RL, S_R1, S_R2, S_RW,
        S_IL, S_I1, S_I2, S_IW,
        S_DONE
    } state_t;

    typedef struct packed {
        logic din_en;
        logic din_addr;
        logic w_addr;
        logic acu_en;
        logic load1;
        logic load2;
        logic cin1;
        logic cin2;
        logic dout_en;
        logic dout_addr;
        logic done;
    } ctrl_t;

    state_t               state_q, state_d;
    ctrl_t                ctrl_q, ctrl_d;
    logic [CNT_WIDTH-1:0] count_q;

    // State and the control word for that state are registered together, so
    // every select/load/cin output comes straight from a flop.
    // NOTE: sequential state uses non-blocking assignments so all flops see
    // pre-edge values; reset is asynchronous and clears every flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    // hold freezes the sequence; start is only looked at in IDLE and DONE.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_d unassigned
        // (otherwise a latch is inferred).
        state_d = state_q;
        if (!hold) begin
            unique case (state_q)
                S_IDLE: if (start) state_d = S_CAP;
                S_CAP:  state_d = S_RL;
                S_RL:   state_d = S_R1;
                S_R1:   state_d = S_R2;
                S_R2:   state_d = S_RW;
                S_RW:   state_d = S_IL;
                S_IL:   state_d = S_I1;
                S_I1:   state_d = S_I2;
                S_I2:   state_d = S_IW;
                S_IW:   state_d = S_DONE;
                S_DONE: state_d = start ? S_CAP : S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Control word for the state about to be entered.
    always_comb begin
        ctrl_d = '0;
        unique case (state_d)
            S_CAP: ctrl_d.din_en = 1'b1;
            S_RL: begin
                ctrl_d.acu_en = 1'b1;
                ctrl_d.load1  = 1'b1;
                ctrl_d.load2  = 1'b1;
            end
            S_R1: begin
                ctrl_d.acu_en = 1'b1;
                ctrl_d.cin2   = 1'b1;
            end
            S_R2: begin
                ctrl_d.din_addr = 1'b1;
                ctrl_d.w_addr   = 1'b1;
                ctrl_d.acu_en   = 1'b1;
                ctrl_d.cin1     = 1'b1;
            end
            S_RW: ctrl_d.dout_en = 1'b1;
            S_IL: begin
                ctrl_d.din_addr = 1'b1;
                ctrl_d.acu_en   = 1'b1;
                ctrl_d.load1    = 1'b1;
                ctrl_d.load2    = 1'b1;
            end
            S_I1: begin
                ctrl_d.w_addr = 1'b1;
                ctrl_d.acu_en = 1'b1;
                ctrl_d.cin2   = 1'b1;
            end
            S_I2: begin
                ctrl_d.din_addr = 1'b1;
                ctrl_d.acu_en   = 1'b1;
                ctrl_d.cin2     = 1'b1;
            end
            S_IW: begin
                ctrl_d.dout_en   = 1'b1;
                ctrl_d.dout_addr = 1'b1;
            end
            S_DONE: ctrl_d.done = 1'b1;
            default: ctrl_d = '0;
        endcase
    end

    // Counts only the cycle where done actually reaches the scheduler.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (ctrl_q.done && !hold) begin
            count_q <= count_q + CNT_WIDTH'(1);
        end
    end

    assign data_in_en    = ctrl_q.din_en  & ~hold;
    assign acu_enable    = ctrl_q.acu_en  & ~hold;
    assign data_out_en   = ctrl_q.dout_en & ~hold;
    assign done          = ctrl_q.done    & ~hold;

    assign data_in_addr  = NO_COMP_WORD'(ctrl_q.din_addr);
    assign w_addr        = ctrl_q.w_addr;
    assign acu_load1     = ctrl_q.load1;
    assign acu_load2     = ctrl_q.load2;
    assign acu_cin1      = ctrl_q.cin1;
    assign acu_cin2      = ctrl_q.cin2;
    assign data_out_addr = ctrl_q.dout_addr;
    assign busy          = (state_q != S_IDLE);
    assign bf_count      = count_q;

endmodule
